drive_controller: RTL

Motion controller that replaces the fixed command decode and two-speed motor mode of the car top level. It consumes validated UART command bytes and obstacle flags from the ultrasonic blocks, and drives per-wheel direction and PWM outputs. It adds parametrised speed levels, duty ramping, a reversal dead-time interlock, a command watchdog and blinking turn/hazard lights. It sits between `rx_module`/`sonic_top` and the H-bridge pins.

---
 rtl/drive_controller.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/drive_controller.sv
// Motion controller for the car: decodes UART command bytes into per-wheel direction/PWM,
// with speed levels, duty ramping, a reversal dead-time, a command watchdog and turn/hazard lights.
module drive_controller #(
    parameter int PWM_BITS       = 8,
    parameter int SPEED_LEVELS   = 4,
    parameter int RAMP_STEP      = 16,
    parameter int RAMP_DIV       = 65536,
    parameter int DEAD_CYCLES    = 1000000,
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int BLINK_DIV      = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    input  logic       stop_front,
    input  logic       stop_back,
    output logic [1:0] left_dir,
    output logic [1:0] right_dir,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic       left_light,
    output logic       right_light,
    output logic [3:0] speed_level,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
    typedef enum logic [1:0] {FWD, REV, TR, TL} dir_t;

    typedef struct packed {
        logic       stop;
        logic       motion;
        dir_t       mdir;
        logic       inc;
        logic       dec;
        logic       set;
        logic [3:0] lvl;
    } cmd_t;

    localparam int RAMP_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DEAD_W  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    // A step larger than the full duty range behaves like a jump straight to target.
    localparam int STEP_C  = (RAMP_STEP < (1 << PWM_BITS)) ? RAMP_STEP : (1 << PWM_BITS) - 1;
    localparam logic [PWM_BITS-1:0] STEP    = PWM_BITS'(STEP_C);
    localparam logic [4:0]          NUM_LVL = 5'(SPEED_LEVELS);
    localparam logic [3:0]          MAX_LVL = 4'(SPEED_LEVELS - 1);

    state_t              state;
    dir_t                dir, pending, pend_nxt;
    cmd_t                cmd;
    logic [1:0]          cmd_m1, l_dir_nxt, r_dir_nxt;
    logic [PWM_BITS-1:0] duty, pwm_cnt, tgt, duty_ramp;
    logic [RAMP_W-1:0]   ramp_cnt;
    logic [DEAD_W-1:0]   dead_cnt;
    logic [WD_W-1:0]     wd_cnt;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink, obs_front, obs_back, hazard;
    logic                ramp_tick, blink_tick, wd_expire;
    logic                blk_dir, blk_cmd, blk_pend, cmd_take;

    function automatic logic [PWM_BITS-1:0] level_duty(input logic [3:0] k);
        return PWM_BITS'(((int'(k) + 1) * (1 << PWM_BITS)) / SPEED_LEVELS - 1);
    endfunction

    assign cmd_m1 = cmd_data[1:0] - 2'd1;

    always_comb begin
        cmd = '0;
        if (cmd_valid) begin
            case (cmd_data)
                8'h00: cmd.stop = 1'b1;
                8'h01, 8'h02, 8'h03, 8'h04: begin
                    cmd.motion = 1'b1;
                    cmd.mdir   = dir_t'(cmd_m1);
                end
                8'h05: cmd.inc = 1'b1;
                8'h06: cmd.dec = 1'b1;
                default: begin
                    cmd.set = (cmd_data[7:4] == 4'h1) && ({1'b0, cmd_data[3:0]} < NUM_LVL);
                    cmd.lvl = cmd_data[3:0];
                end
            endcase
        end
    end

    assign blk_dir    = (dir == REV) ? stop_back : stop_front;
    assign blk_cmd    = (cmd.mdir == REV) ? stop_back : stop_front;
    assign cmd_take   = cmd.motion && !blk_cmd;
    assign pend_nxt   = cmd_take ? cmd.mdir : pending;
    assign blk_pend   = (pend_nxt == REV) ? stop_back : stop_front;
    assign ramp_tick  = ramp_cnt == RAMP_W'(RAMP_DIV - 1);
    assign blink_tick = blink_cnt == BLINK_W'(BLINK_DIV - 1);
    // A command in the expiry cycle wins, so expiry requires an idle strobe.
    assign wd_expire  = (TIMEOUT_CYCLES != 0) && !cmd_valid && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign tgt        = level_duty(speed_level);
    assign hazard     = timeout || (state == IDLE && ((obs_front && stop_front) || (obs_back && stop_back)));

    always_comb begin
        duty_ramp = duty;
        if (tgt > duty)      duty_ramp = (tgt - duty > STEP) ? duty + STEP : tgt;
        else if (tgt < duty) duty_ramp = (duty - tgt > STEP) ? duty - STEP : tgt;
    end

    always_comb begin
        l_dir_nxt = 2'b00;
        r_dir_nxt = 2'b00;
        if (state == RUN) begin
            case (dir)
                FWD: begin l_dir_nxt = 2'b10; r_dir_nxt = 2'b10; end
                REV: begin l_dir_nxt = 2'b01; r_dir_nxt = 2'b01; end
                TR:  l_dir_nxt = 2'b10;
                TL:  r_dir_nxt = 2'b10;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            dir         <= FWD;
            pending     <= FWD;
            duty        <= '0;
            pwm_cnt     <= '0;
            ramp_cnt    <= '0;
            dead_cnt    <= '0;
            wd_cnt      <= '0;
            blink_cnt   <= '0;
            blink       <= 1'b0;
            obs_front   <= 1'b0;
            obs_back    <= 1'b0;
            left_dir    <= 2'b00;
            right_dir   <= 2'b00;
            left_pwm    <= 1'b0;
            right_pwm   <= 1'b0;
            left_light  <= 1'b0;
            right_light <= 1'b0;
            speed_level <= '0;
            timeout     <= 1'b0;
        end else begin
            pwm_cnt   <= pwm_cnt + 1'b1;
            ramp_cnt  <= ramp_tick ? '0 : ramp_cnt + 1'b1;
            blink_cnt <= blink_tick ? '0 : blink_cnt + 1'b1;
            if (blink_tick) blink <= !blink;

            left_dir    <= l_dir_nxt;
            right_dir   <= r_dir_nxt;
            left_pwm    <= (pwm_cnt < duty) && (l_dir_nxt != 2'b00);
            right_pwm   <= (pwm_cnt < duty) && (r_dir_nxt != 2'b00);
            left_light  <= blink && (hazard || (state == RUN && dir == TL));
            right_light <= blink && (hazard || (state == RUN && dir == TR));

            if (cmd.inc && speed_level != MAX_LVL) speed_level <= speed_level + 1'b1;
            if (cmd.dec && speed_level != 4'd0)    speed_level <= speed_level - 1'b1;
            if (cmd.set)                           speed_level <= cmd.lvl;

            // Counter saturates at the limit so expiry keeps holding IDLE until a command.
            if (cmd_valid) begin
                wd_cnt  <= '0;
                timeout <= 1'b0;
            end else if (wd_expire) begin
                timeout <= 1'b1;
            end else begin
                wd_cnt  <= wd_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    obs_front <= obs_front && stop_front;
                    obs_back  <= obs_back && stop_back;
                    if (cmd_take) begin
                        state     <= RUN;
                        dir       <= cmd.mdir;
                        duty      <= '0;
                        obs_front <= 1'b0;
                        obs_back  <= 1'b0;
                    end
                end
                RUN: begin
                    if (blk_dir) begin
                        state     <= IDLE;
                        duty      <= '0;
                        obs_front <= (dir != REV);
                        obs_back  <= (dir == REV);
                    end else if (cmd.stop) begin
                        state <= IDLE;
                        duty  <= '0;
                    end else if (cmd_take && cmd.mdir != dir) begin
                        state    <= DEAD;
                        pending  <= cmd.mdir;
                        dead_cnt <= '0;
                        duty     <= '0;
                    end else if (ramp_tick) begin
                        duty <= duty_ramp;
                    end
                end
                DEAD: begin
                    pending <= pend_nxt;
                    if (blk_pend) begin
                        state     <= IDLE;
                        obs_front <= (pend_nxt != REV);
                        obs_back  <= (pend_nxt == REV);
                    end else if (cmd.stop) begin
                        state <= IDLE;
                    end else if (cmd_take) begin
                        dead_cnt <= '0;
                    end else if (dead_cnt == DEAD_W'(DEAD_CYCLES - 1)) begin
                        state <= RUN;
                        dir   <= pending;
                    end else begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (wd_expire) begin
                state <= IDLE;
                duty  <= '0;
            end
        end
    end
endmodule
